// File: rtl/sound_seek_ctrl.sv
// Sound-seek sequencer: arms a direction finder, collects matching votes,
// commands a motor turn, waits for completion and settles before returning idle.
module sound_seek_ctrl #(
    parameter int unsigned VOTES          = 3,
    parameter int unsigned LISTEN_TIMEOUT = 5_000_000,
    parameter int unsigned COOLDOWN       = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] direction,
    input  logic       turn_ack,
    input  logic       turn_done,
    output logic       finder_en,
    output logic       turn_req,
    output logic [1:0] turn_dir,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    localparam int unsigned TW = 24;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LISTEN, S_TURN, S_WAIT_DONE, S_COOLDOWN
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [CW-1:0] count, count_n;
    logic [1:0]    vote, vote_n;

    logic       finder_en_n, turn_req_n, busy_n, done_n, timeout_n;
    logic [1:0] turn_dir_n;
    logic       detect;

    assign detect = (direction == 2'b01) || (direction == 2'b10);

    // State, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            count     <= '0;
            vote      <= 2'b00;
            finder_en <= 1'b0;
            turn_req  <= 1'b0;
            turn_dir  <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            count     <= count_n;
            vote      <= vote_n;
            finder_en <= finder_en_n;
            turn_req  <= turn_req_n;
            turn_dir  <= turn_dir_n;
            busy      <= busy_n;
            done      <= done_n;
            timeout   <= timeout_n;
        end
    end

    // Next-state and working-register update
    always_comb begin
        state_n = state;
        timer_n = timer;
        count_n = count;
        vote_n  = vote;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ARM;
                    timer_n = '0;
                    count_n = '0;
                    vote_n  = 2'b00;
                end
            end
            S_ARM: begin
                // finder held low for two cycles so its latched result clears
                if (timer == TW'(1)) begin
                    state_n = S_LISTEN;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_LISTEN: begin
                if (detect) begin
                    if (direction == vote) begin
                        count_n = count + CW'(1);
                    end else begin
                        count_n = CW'(1);
                        vote_n  = direction;
                    end
                    if (count_n == CW'(VOTES)) begin
                        state_n = S_TURN;
                    end else begin
                        state_n = S_ARM;
                        timer_n = '0;
                    end
                end else if (timer == TW'(LISTEN_TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_TURN: begin
                if (turn_ack) state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (turn_done) begin
                    state_n = S_COOLDOWN;
                    timer_n = '0;
                end
            end
            S_COOLDOWN: begin
                if (timer == TW'(COOLDOWN - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    // Output values for the coming cycle, derived from the transition taken
    always_comb begin
        finder_en_n = 1'b0;
        turn_req_n  = 1'b0;
        turn_dir_n  = 2'b00;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        timeout_n   = 1'b0;
        finder_en_n = (state_n == S_LISTEN);
        turn_req_n  = (state_n == S_TURN);
        busy_n      = (state_n != S_IDLE);
        if (state_n == S_TURN) turn_dir_n = vote_n;
        done_n      = !abort && (state == S_COOLDOWN) && (state_n == S_IDLE);
        timeout_n   = !abort && (state == S_LISTEN) && (state_n == S_IDLE);
    end

endmodule

// File: tb/tb_sound_seek_ctrl.sv
// Randomized scoreboard bench for sound_seek_ctrl: a sequence-level timing
// predictor queues expected output changes; a monitor checks every change.
module tb_sound_seek_ctrl;

    localparam int unsigned VOTES = 3;
    localparam int unsigned LT    = 100;
    localparam int unsigned CD    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] direction = 2'b00;
    logic       turn_ack = 1'b0;
    logic       turn_done = 1'b0;
    logic       finder_en, turn_req, busy, done, timeout;
    logic [1:0] turn_dir;

    sound_seek_ctrl #(.VOTES(VOTES), .LISTEN_TIMEOUT(LT), .COOLDOWN(CD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .direction(direction), .turn_ack(turn_ack), .turn_done(turn_done),
        .finder_en(finder_en), .turn_req(turn_req), .turn_dir(turn_dir),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;

    ev_t        q[$];
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev = 7'd0;

    // Reference model state: current vote count and stored direction
    int         cnt = 0;
    logic [1:0] vote = 2'b00;

    function automatic void push(int c, logic en, logic req, logic [1:0] dir,
                                 logic bsy, logic dn, logic to);
        ev_t e;
        e.c = c;
        e.v = {en, req, dir, bsy, dn, to};
        q.push_back(e);
    endfunction

    // Monitor: every change of the output vector must match the next prediction
    always @(negedge clk) begin
        logic [6:0] cur;
        ev_t        e;
        cur = {finder_en, turn_req, turn_dir, busy, done, timeout};
        if (mon_en && cur !== prev) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: cyc=%0d got=%b, none required", cyc, cur);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v !== cur) begin
                    bad++;
                    $display("FAIL out_change: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                             cyc, cur, e.c, e.v);
                end
            end
            prev = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        direction = ($urandom % 2 == 0) ? 2'b11 : 2'b00;
        start     = ($urandom % 4 == 0);
    endtask

    task automatic do_start();
        direction = 2'b00;
        start = 1'b1;
        tick();
        push(cyc, 0, 0, 2'b00, 1, 0, 0);
        start = 1'b0;
        cnt = 0;
        vote = 2'b00;
        direction = 2'($urandom);
        tick();
        direction = 2'($urandom);
        tick();
        direction = 2'b00;
        push(cyc, 1, 0, 2'b00, 1, 0, 0);
    endtask

    task automatic detect(int g, logic [1:0] d);
        for (int i = 0; i < g; i++) begin
            noise();
            tick();
        end
        start = 1'b0;
        direction = d;
        tick();
        direction = 2'b00;
        if (d == vote) cnt++;
        else begin
            cnt = 1;
            vote = d;
        end
        if (cnt == int'(VOTES)) begin
            push(cyc, 0, 1, d, 1, 0, 0);
        end else begin
            push(cyc, 0, 0, 2'b00, 1, 0, 0);
            direction = 2'($urandom);
            tick();
            direction = 2'($urandom);
            tick();
            direction = 2'b00;
            push(cyc, 1, 0, 2'b00, 1, 0, 0);
        end
    endtask

    task automatic gather_votes();
        logic [1:0] d;
        int         g;
        for (int i = 0; i < 40 && cnt < int'(VOTES); i++) begin
            if (i >= 10 || (vote != 2'b00 && $urandom % 4 != 0)) d = (vote == 2'b00) ? 2'b01 : vote;
            else d = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
            g = ($urandom % 8 == 0) ? int'(LT) - 1 : int'($urandom % 20);
            detect(g, d);
        end
    endtask

    task automatic timeout_window();
        for (int i = 0; i < int'(LT); i++) begin
            noise();
            tick();
        end
        start = 1'b0;
        direction = 2'b00;
        push(cyc, 0, 0, 2'b00, 0, 0, 1);
        tick();
        push(cyc, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic ack_turn(int ad);
        for (int i = 0; i < ad; i++) begin
            turn_done = 1'($urandom);
            tick();
        end
        turn_done = 1'b0;
        turn_ack = 1'b1;
        tick();
        turn_ack = 1'b0;
        push(cyc, 0, 0, 2'b00, 1, 0, 0);
    endtask

    task automatic finish_turn(int w);
        for (int i = 0; i < w; i++) begin
            turn_ack = 1'($urandom);
            tick();
        end
        turn_ack = 1'b0;
        turn_done = 1'b1;
        tick();
        turn_done = 1'b0;
        for (int i = 0; i < int'(CD) - 1; i++) begin
            start = 1'($urandom);
            turn_done = 1'($urandom);
            tick();
        end
        start = 1'($urandom);
        tick();
        push(cyc, 0, 0, 2'b00, 0, 1, 0);
        start = 1'b0;
        turn_done = 1'b0;
        tick();
        push(cyc, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic abort_now();
        abort = 1'b1;
        start = 1'($urandom);
        tick();
        abort = 1'b0;
        start = 1'b0;
        push(cyc, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic idle_gap();
        int n;
        n = 1 + int'($urandom % 5);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            direction = 2'($urandom);
            turn_ack  = 1'($urandom);
            turn_done = 1'($urandom);
            abort     = 1'($urandom);
            start     = abort;
            tick();
        end
        direction = 2'b00;
        turn_ack = 1'b0;
        turn_done = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({finder_en, turn_req, turn_dir, busy, done, timeout} !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: got=%b required=%b",
                     {finder_en, turn_req, turn_dir, busy, done, timeout}, 7'd0);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Three rightward votes, full turn and cooldown
        do_start();
        detect(3, 2'b01);
        detect(0, 2'b01);
        detect(int'(LT) - 1, 2'b01);
        ack_turn(2);
        finish_turn(3);
        idle_gap();

        // A leftward change of mind resets the count
        do_start();
        detect(5, 2'b01);
        detect(1, 2'b10);
        detect(2, 2'b10);
        detect(7, 2'b10);
        ack_turn(0);
        finish_turn(0);
        idle_gap();

        // Silent listen window times out
        do_start();
        timeout_window();
        idle_gap();

        // Abort while the turn request is pending
        do_start();
        gather_votes();
        for (int i = 0; i < 3; i++) tick();
        abort_now();
        idle_gap();

        // Reset during cooldown, then a complete sequence
        do_start();
        gather_votes();
        ack_turn(1);
        turn_done = 1'b1;
        tick();
        turn_done = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        push(cyc, 0, 0, 2'b00, 0, 0, 0);
        idle_gap();
        do_start();
        gather_votes();
        ack_turn(0);
        finish_turn(1);
        idle_gap();

        for (int s = 0; s < 30; s++) begin
            case ($urandom % 5)
                0: begin
                    do_start();
                    gather_votes();
                    ack_turn(int'($urandom % 4));
                    finish_turn(int'($urandom % 4));
                end
                1: begin
                    do_start();
                    if ($urandom % 2 == 0) detect(int'($urandom % 20), ($urandom % 2 == 0) ? 2'b01 : 2'b10);
                    timeout_window();
                end
                2: begin
                    do_start();
                    gather_votes();
                    for (int i = 0; i < int'($urandom % 3); i++) tick();
                    abort_now();
                end
                3: begin
                    do_start();
                    for (int i = 0; i < int'($urandom % 30); i++) begin
                        noise();
                        tick();
                    end
                    abort_now();
                end
                default: begin
                    do_start();
                    gather_votes();
                    ack_turn(int'($urandom % 3));
                    finish_turn(int'($urandom % 3));
                    abort = 1'b1;
                    start = 1'b1;
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                end
            endcase
            idle_gap();
        end

        for (int i = 0; i < 4; i++) tick();
        mon_en = 1'b0;
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_change: not observed, required cyc=%0d vec=%b", e.c, e.v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
